paren_traceback: RTL and testbench
==================================

Name: paren_traceback

Overview:
- Downstream of the chain-multiplier top level: once the cost/split tables are filled, this block walks the split table s[i][j] from s[1][n].
- It emits the optimal parenthesization as a token stream (OPEN, MAT idx, CLOSE) over a valid/ready handshake.
- It is a stack-based iterative traversal with a synchronous single-port read into the solution matrix.
- Matrix indices are 1-based, the same convention as the solution matrix.

Parameters:
- MAX_N, 32: maximum chain length supported.
- IDX_W, 8: width of i, j, k and index fields.
- STACK_DEPTH, 2*MAX_N: work-stack entries.

Ports:
- clk1  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- n  in  IDX_W  chain length; sampled on an accepted start.
- k_rd_en  out  1  split-table read strobe.
- k_i  out  IDX_W  row address.
- k_j  out  IDX_W  column address.
- k_data  in  IDX_W  s[k_i][k_j], valid exactly 1 cycle after k_rd_en.
- tok_valid  out  1  token valid.
- tok_ready  in  1  consumer ready.
- tok_type  out  2  token type: 0 MAT, 1 OPEN, 2 CLOSE.
- tok_idx  out  IDX_W  matrix index; meaningful for MAT only, else 0.
- busy  out  1  high from start acceptance until DONE/ERR exit.
- done  out  1  one-cycle pulse after the last token is accepted.
- err  out  1  sticky until the next accepted start.

Behaviour:
- Reset (rst=0, async) forces state=IDLE, stack pointer=0, and all outputs to 0.
- Work item: {kind (RANGE/CLOSE), i, j}.
- Accepted start with 1<=n<=MAX_N: push RANGE(1,n), set busy=1, go to POP.
- start with n=0 or n>MAX_N: assert err, no tokens, done pulses the next cycle, return to IDLE.
- POP:
  - stack empty: go to DONE.
  - otherwise pop the top item.
  - CLOSE: go to EMIT with tok CLOSE.
  - RANGE with i==j: go to EMIT with tok MAT i.
  - RANGE with i<j: drive k_rd_en=1, k_i=i, k_j=j; go to WAIT.
- WAIT: capture k=k_data.
  - Legal split requires i<=k<j.
  - Illegal k: go to ERR (err=1); no further tokens.
  - Legal k: go to EMIT with tok OPEN, then PUSH.
- PUSH: push CLOSE, then RANGE(k+1,j), then RANGE(i,k), at one push per cycle (3 cycles). Return to POP.
- EMIT:
  - tok_valid=1; fields hold stable until tok_ready.
  - Transfer occurs in the cycle tok_valid&&tok_ready.
  - Next state after transfer: PUSH if the token was OPEN, else POP.
  - tok_valid never deasserts without a transfer.
- Push with sp==STACK_DEPTH: go to ERR. Overflow is unreachable for legal tables but must be guarded.
- DONE: done=1 for one cycle, busy=0, go to IDLE.
- ERR: done=1 for one cycle, busy=0, err stays 1, go to IDLE.
- start while busy is ignored.
- Reset mid-operation: the traversal is abandoned and no partial token is held.
- Token count for legal n is 3n-2: n MAT, n-1 OPEN, n-1 CLOSE.
- Minimum cost per internal node is 1 POP + 1 WAIT + 1 EMIT + 3 PUSH cycles, with zero backpressure.

Optional Feature:
- Macro PAREN_MULT_COUNT_EN.
- Defined:
  - adds output mult_cnt [IDX_W-1:0], cleared on accepted start and incremented on each transferred CLOSE token.
  - adds output cnt_mismatch, asserted with done if mult_cnt != n-1 and err=0.
- Undefined: neither port exists, and behaviour is otherwise identical.

Decomposition:
- Shared package:
  - token type constants TOK_MAT/TOK_OPEN/TOK_CLOSE.
  - work-item kind constants.
  - state encoding IDLE/POP/WAIT/EMIT/PUSH/DONE/ERR.
  - IDX_W default.
- One sub-module: paren_stack (synchronous LIFO; push/pop/full/empty; combinational top). It is instantiated with width 1+2*IDX_W and depth STACK_DEPTH.

Test Plan:
- n=1, start -> tokens {MAT 1}; then done pulse, err=0; no k_rd_en ever asserted.
- n=3, s[1][3]=1, s[2][3]=2, tok_ready=1 -> OPEN, MAT1, OPEN, MAT2, MAT3, CLOSE, CLOSE (7 tokens); done; mult_cnt=2 if enabled.
- n=4, s[1][4]=2, s[1][2]=1, s[3][4]=3, tok_ready toggling 1-0-1 -> ((M1 M2)(M3 M4)); each token held stable while tok_ready=0; 10 tokens total.
- n=3, s[1][3]=3 (illegal) -> OPEN never emitted, err=1, done pulse, busy=0.
- n=0 -> err=1, zero tokens; n=MAX_N+1 -> same response.
- n=5 traversal, rst low after 4 tokens -> all outputs 0 immediately; then start with n=2, s[1][2]=1 -> OPEN, MAT1, MAT2, CLOSE, err=0.

Source files
------------

// File: rtl/paren_traceback_pkg.sv
// Shared constants for the parenthesization traceback: token types, work-item kinds and
// FSM state encoding.
package paren_traceback_pkg;

    localparam int unsigned IDX_W_DEFAULT = 8;

    localparam logic [1:0] TOK_MAT   = 2'd0;
    localparam logic [1:0] TOK_OPEN  = 2'd1;
    localparam logic [1:0] TOK_CLOSE = 2'd2;

    localparam logic KIND_RANGE = 1'b0;
    localparam logic KIND_CLOSE = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StPop,
        StWait,
        StEmit,
        StPush,
        StDone,
        StErr
    } state_e;

endpackage

// File: rtl/paren_stack.sv
// Synchronous LIFO work stack with a combinational top-of-stack view and a bulk clear.
module paren_stack #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 64
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);
    localparam int unsigned SP_W = $clog2(DEPTH + 1);
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [SP_W-1:0]  sp;
    logic [AW-1:0]    wr_addr, rd_addr;

    assign wr_addr = AW'(sp);
    assign rd_addr = AW'(sp - SP_W'(1));
    assign full    = sp == SP_W'(DEPTH);
    assign empty   = sp == '0;
    assign top     = empty ? '0 : mem[rd_addr];

    always_ff @(posedge clk1) begin
        if (push && !full) mem[wr_addr] <= push_data;
    end

    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst)                sp <= '0;
        else if (clr)            sp <= '0;
        else if (push && !full)  sp <= sp + SP_W'(1);
        else if (pop && !empty)  sp <= sp - SP_W'(1);
    end

endmodule

// File: rtl/paren_traceback.sv
// Walks the split table from s[1][n] and streams OPEN / MAT idx / CLOSE tokens (valid/ready).
// Defining PAREN_MULT_COUNT_EN adds mult_cnt and cnt_mismatch outputs.
module paren_traceback
    import paren_traceback_pkg::*;
#(
    parameter int unsigned MAX_N       = 32,
    parameter int unsigned IDX_W       = IDX_W_DEFAULT,
    parameter int unsigned STACK_DEPTH = 2 * MAX_N
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W-1:0] n,
    output logic             k_rd_en,
    output logic [IDX_W-1:0] k_i,
    output logic [IDX_W-1:0] k_j,
    input  logic [IDX_W-1:0] k_data,
    output logic             tok_valid,
    input  logic             tok_ready,
    output logic [1:0]       tok_type,
    output logic [IDX_W-1:0] tok_idx,
`ifdef PAREN_MULT_COUNT_EN
    output logic [IDX_W-1:0] mult_cnt,
    output logic             cnt_mismatch,
`endif
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int unsigned ITEM_W = 1 + 2 * IDX_W;

    state_e           state;
    logic [IDX_W-1:0] cur_i, cur_j, cur_k;
    logic [1:0]       push_cnt;
    logic             stk_clr, stk_push, stk_pop, stk_full, stk_empty;
    logic [ITEM_W-1:0] push_item, top_item;
    logic             top_kind;
    logic [IDX_W-1:0] top_i, top_j;
    logic             n_ok, k_ok;

    assign {top_kind, top_i, top_j} = top_item;
    assign n_ok    = (n != '0) && (32'(n) <= MAX_N);
    assign k_ok    = (k_data >= cur_i) && (k_data < cur_j);
    assign stk_clr = state == StErr;

    paren_stack #(
        .WIDTH (ITEM_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk1      (clk1),
        .rst       (rst),
        .clr       (stk_clr),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (push_item),
        .top       (top_item),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // Split-table read is issued from POP directly so k_data lands during WAIT.
    always_comb begin
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        push_item = '0;
        k_rd_en   = 1'b0;
        k_i       = '0;
        k_j       = '0;
        unique case (state)
            StIdle: begin
                if (start && n_ok) begin
                    stk_push  = 1'b1;
                    push_item = {KIND_RANGE, IDX_W'(1), n};
                end
            end
            StPop: begin
                if (!stk_empty) begin
                    stk_pop = 1'b1;
                    if (top_kind == KIND_RANGE && top_i < top_j) begin
                        k_rd_en = 1'b1;
                        k_i     = top_i;
                        k_j     = top_j;
                    end
                end
            end
            StPush: begin
                stk_push = !stk_full;
                unique case (push_cnt)
                    2'd0:    push_item = {KIND_CLOSE, cur_i, cur_j};
                    2'd1:    push_item = {KIND_RANGE, cur_k + IDX_W'(1), cur_j};
                    default: push_item = {KIND_RANGE, cur_i, cur_k};
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            state     <= StIdle;
            cur_i     <= '0;
            cur_j     <= '0;
            cur_k     <= '0;
            push_cnt  <= '0;
            tok_valid <= 1'b0;
            tok_type  <= TOK_MAT;
            tok_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start && n_ok) begin
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        state <= StPop;
                    end else if (start) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= StErr;
                    end
                end
                StPop: begin
                    if (stk_empty) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= StDone;
                    end else if (top_kind == KIND_CLOSE) begin
                        tok_valid <= 1'b1;
                        tok_type  <= TOK_CLOSE;
                        tok_idx   <= '0;
                        state     <= StEmit;
                    end else if (top_i == top_j) begin
                        tok_valid <= 1'b1;
                        tok_type  <= TOK_MAT;
                        tok_idx   <= top_i;
                        state     <= StEmit;
                    end else if (top_i < top_j) begin
                        cur_i <= top_i;
                        cur_j <= top_j;
                        state <= StWait;
                    end else begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= StErr;
                    end
                end
                StWait: begin
                    if (k_ok) begin
                        cur_k     <= k_data;
                        tok_valid <= 1'b1;
                        tok_type  <= TOK_OPEN;
                        tok_idx   <= '0;
                        state     <= StEmit;
                    end else begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= StErr;
                    end
                end
                StEmit: begin
                    if (tok_ready) begin
                        tok_valid <= 1'b0;
                        tok_type  <= TOK_MAT;
                        tok_idx   <= '0;
                        push_cnt  <= '0;
                        state     <= (tok_type == TOK_OPEN) ? StPush : StPop;
                    end
                end
                StPush: begin
                    if (stk_full) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= StErr;
                    end else if (push_cnt == 2'd2) begin
                        push_cnt <= '0;
                        state    <= StPop;
                    end else begin
                        push_cnt <= push_cnt + 2'd1;
                    end
                end
                StDone, StErr: begin
                    done  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef PAREN_MULT_COUNT_EN
    logic [IDX_W-1:0] n_q;

    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            mult_cnt     <= '0;
            n_q          <= '0;
            cnt_mismatch <= 1'b0;
        end else begin
            if (state == StIdle && start) begin
                mult_cnt <= '0;
                n_q      <= n;
            end else if (tok_valid && tok_ready && tok_type == TOK_CLOSE) begin
                mult_cnt <= mult_cnt + IDX_W'(1);
            end
            // Lines up with done on the POP->DONE exit only.
            cnt_mismatch <= (state == StPop) && stk_empty && !err &&
                            (mult_cnt != n_q - IDX_W'(1));
        end
    end
`endif

endmodule

// File: tb/tb_paren_traceback.sv
// Directed bench for paren_traceback: token streams, backpressure, error paths, mid-run reset.
module tb_paren_traceback;

    logic       clk1 = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       tok_ready = 1'b0;
    logic [7:0] n = 8'd0;
    logic [7:0] k_data;
    logic       k_rd_en, tok_valid, busy, done, err;
    logic [7:0] k_i, k_j, tok_idx;
    logic [1:0] tok_type;
`ifdef PAREN_MULT_COUNT_EN
    logic [7:0] mult_cnt;
    logic       cnt_mismatch;
`endif

    int checks = 0;
    int failures = 0;

    logic [7:0] smat [0:63][0:63];
    logic [1:0] log_type [0:255];
    logic [7:0] log_idx [0:255];
    int         tok_cnt = 0;
    int         done_cnt = 0;
    int         rd_cnt = 0;
    int         hold_viol = 0;
    logic       pend = 1'b0;
    logic [1:0] pend_type = 2'd0;
    logic [7:0] pend_idx = 8'd0;

    always #5 clk1 = ~clk1;

    paren_traceback #(
        .MAX_N       (32),
        .IDX_W       (8),
        .STACK_DEPTH (64)
    ) dut (
        .clk1         (clk1),
        .rst          (rst),
        .start        (start),
        .n            (n),
        .k_rd_en      (k_rd_en),
        .k_i          (k_i),
        .k_j          (k_j),
        .k_data       (k_data),
        .tok_valid    (tok_valid),
        .tok_ready    (tok_ready),
        .tok_type     (tok_type),
        .tok_idx      (tok_idx),
`ifdef PAREN_MULT_COUNT_EN
        .mult_cnt     (mult_cnt),
        .cnt_mismatch (cnt_mismatch),
`endif
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    // Split-table memory: one-cycle read latency.
    always @(posedge clk1) k_data <= k_rd_en ? smat[k_i[5:0]][k_j[5:0]] : 8'h00;

    always @(posedge clk1) begin
        if (!rst) begin
            pend <= 1'b0;
        end else begin
            if (pend && !(tok_valid && tok_type == pend_type && tok_idx == pend_idx))
                hold_viol <= hold_viol + 1;
            if (tok_valid && tok_ready) begin
                log_type[tok_cnt[7:0]] <= tok_type;
                log_idx[tok_cnt[7:0]]  <= tok_idx;
                tok_cnt <= tok_cnt + 1;
            end
            pend      <= tok_valid && !tok_ready;
            pend_type <= tok_type;
            pend_idx  <= tok_idx;
            if (done) done_cnt <= done_cnt + 1;
            if (k_rd_en) rd_cnt <= rd_cnt + 1;
        end
    end

    task automatic clear_table();
        for (int i = 0; i < 64; i++)
            for (int j = 0; j < 64; j++) smat[i][j] = 8'd0;
    endtask

    task automatic pulse_start(input logic [7:0] nv);
        @(negedge clk1);
        n     = nv;
        start = 1'b1;
        @(negedge clk1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        int base;
        base = done_cnt;
        seen = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk1);
            if (done_cnt > base) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        tok_ready = 1'b1;
        clear_table();
        #12;
        checks++;
        if ({busy, done, err, tok_valid, k_rd_en} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b exp 00000", {busy, done, err, tok_valid, k_rd_en});
        end
        checks++;
        if ({tok_type, tok_idx, k_i, k_j} !== 26'd0) begin
            failures++;
            $display("FAIL reset_fields: got %h exp 0", {tok_type, tok_idx, k_i, k_j});
        end
        @(negedge clk1);
        rst = 1'b1;
        repeat (2) @(negedge clk1);
        checks++;
        if ({busy, tok_valid, done} !== 3'b0) begin
            failures++;
            $display("FAIL reset_idle: got %b exp 000", {busy, tok_valid, done});
        end
    endtask

    task automatic test_single();
        int base, rd0;
        bit seen;
        clear_table();
        base = tok_cnt;
        rd0  = rd_cnt;
        pulse_start(8'd1);
        wait_done(50, seen);
        checks++;
        if (!seen) begin failures++; $display("FAIL single_done: got 0 exp 1"); end
        checks++;
        if (tok_cnt - base != 1) begin
            failures++;
            $display("FAIL single_count: got %0d exp 1", tok_cnt - base);
        end
        checks++;
        if (log_type[8'(base)] !== 2'd0 || log_idx[8'(base)] !== 8'd1) begin
            failures++;
            $display("FAIL single_tok: got type %0d idx %0d exp type 0 idx 1",
                     log_type[8'(base)], log_idx[8'(base)]);
        end
        checks++;
        if (rd_cnt != rd0) begin
            failures++;
            $display("FAIL single_no_read: got %0d reads exp 0", rd_cnt - rd0);
        end
        checks++;
        if ({err, busy} !== 2'b00) begin
            failures++;
            $display("FAIL single_err_busy: got %b exp 00", {err, busy});
        end
    endtask

    task automatic test_n3();
        int base;
        bit seen;
        logic [1:0] et [7];
        logic [7:0] ei [7];
        et = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd0, 2'd2, 2'd2};
        ei = '{8'd0, 8'd1, 8'd0, 8'd2, 8'd3, 8'd0, 8'd0};
        clear_table();
        smat[1][3] = 8'd1;
        smat[2][3] = 8'd2;
        tok_ready  = 1'b1;
        base = tok_cnt;
        pulse_start(8'd3);
        wait_done(200, seen);
        checks++;
        if (!seen || tok_cnt - base != 7) begin
            failures++;
            $display("FAIL n3_count: got seen %0d count %0d exp seen 1 count 7", seen, tok_cnt - base);
        end
        for (int t = 0; t < 7; t++) begin
            checks++;
            if (log_type[8'(base + t)] !== et[t] || log_idx[8'(base + t)] !== ei[t]) begin
                failures++;
                $display("FAIL n3_tok%0d: got type %0d idx %0d exp type %0d idx %0d", t,
                         log_type[8'(base + t)], log_idx[8'(base + t)], et[t], ei[t]);
            end
        end
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL n3_err: got %b exp 0", err); end
`ifdef PAREN_MULT_COUNT_EN
        checks++;
        if (mult_cnt !== 8'd2) begin
            failures++;
            $display("FAIL n3_mult_cnt: got %0d exp 2", mult_cnt);
        end
`endif
    endtask

    task automatic test_back_to_back_backpressure();
        int base, hv0, base_done;
        bit seen;
        logic [1:0] et [10];
        logic [7:0] ei [10];
        et = '{2'd1, 2'd1, 2'd0, 2'd0, 2'd2, 2'd1, 2'd0, 2'd0, 2'd2, 2'd2};
        ei = '{8'd0, 8'd0, 8'd1, 8'd2, 8'd0, 8'd0, 8'd3, 8'd4, 8'd0, 8'd0};
        clear_table();
        smat[1][4] = 8'd2;
        smat[1][2] = 8'd1;
        smat[3][4] = 8'd3;
        base      = tok_cnt;
        hv0       = hold_viol;
        base_done = done_cnt;
        tok_ready = 1'b1;
        pulse_start(8'd4);
        seen = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk1);
            tok_ready = ~tok_ready;
            // A start while busy must be ignored.
            start = (c == 6);
            n     = (c == 6) ? 8'd1 : 8'd4;
            if (done_cnt > base_done) begin
                seen = 1'b1;
                break;
            end
        end
        start     = 1'b0;
        tok_ready = 1'b1;
        repeat (4) @(negedge clk1);
        checks++;
        if (!seen || tok_cnt - base != 10) begin
            failures++;
            $display("FAIL bp_count: got seen %0d count %0d exp seen 1 count 10", seen, tok_cnt - base);
        end
        for (int t = 0; t < 10; t++) begin
            checks++;
            if (log_type[8'(base + t)] !== et[t] || log_idx[8'(base + t)] !== ei[t]) begin
                failures++;
                $display("FAIL bp_tok%0d: got type %0d idx %0d exp type %0d idx %0d", t,
                         log_type[8'(base + t)], log_idx[8'(base + t)], et[t], ei[t]);
            end
        end
        checks++;
        if (hold_viol != hv0) begin
            failures++;
            $display("FAIL bp_hold: got %0d violations exp 0", hold_viol - hv0);
        end
        checks++;
        if ({err, busy} !== 2'b00 || done_cnt - base_done != 1) begin
            failures++;
            $display("FAIL bp_end: got err %b busy %b dones %0d exp 0 0 1", err, busy,
                     done_cnt - base_done);
        end
    endtask

    task automatic test_illegal_split();
        int base, rd0;
        bit seen;
        clear_table();
        smat[1][3] = 8'd3;
        tok_ready  = 1'b1;
        base = tok_cnt;
        rd0  = rd_cnt;
        pulse_start(8'd3);
        wait_done(50, seen);
        checks++;
        if (!seen) begin failures++; $display("FAIL illegal_done: got 0 exp 1"); end
        checks++;
        if (tok_cnt != base) begin
            failures++;
            $display("FAIL illegal_tokens: got %0d exp 0", tok_cnt - base);
        end
        checks++;
        if ({err, busy} !== 2'b10) begin
            failures++;
            $display("FAIL illegal_err_busy: got %b exp 10", {err, busy});
        end
        checks++;
        if (rd_cnt - rd0 != 1) begin
            failures++;
            $display("FAIL illegal_reads: got %0d exp 1", rd_cnt - rd0);
        end
    endtask

    task automatic test_bad_n();
        int base;
        bit seen;
        clear_table();
        base = tok_cnt;
        pulse_start(8'd0);
        wait_done(3, seen);
        checks++;
        if (!seen || {err, busy} !== 2'b10 || tok_cnt != base) begin
            failures++;
            $display("FAIL bad_n0: got seen %0d err %b busy %b tokens %0d exp 1 1 0 0",
                     seen, err, busy, tok_cnt - base);
        end
        pulse_start(8'd1);
        wait_done(50, seen);
        checks++;
        if (!seen || err !== 1'b0) begin
            failures++;
            $display("FAIL err_clears: got seen %0d err %b exp 1 0", seen, err);
        end
        base = tok_cnt;
        pulse_start(8'd33);
        wait_done(3, seen);
        checks++;
        if (!seen || {err, busy} !== 2'b10 || tok_cnt != base) begin
            failures++;
            $display("FAIL bad_n33: got seen %0d err %b busy %b tokens %0d exp 1 1 0 0",
                     seen, err, busy, tok_cnt - base);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        bit seen, hit;
        logic [1:0] et [4];
        logic [7:0] ei [4];
        et = '{2'd1, 2'd0, 2'd0, 2'd2};
        ei = '{8'd0, 8'd1, 8'd2, 8'd0};
        clear_table();
        smat[1][5] = 8'd2;
        smat[1][2] = 8'd1;
        smat[3][5] = 8'd3;
        smat[4][5] = 8'd4;
        tok_ready  = 1'b1;
        base = tok_cnt;
        pulse_start(8'd5);
        hit = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (tok_cnt - base >= 4) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk1);
        end
        checks++;
        if (!hit) begin failures++; $display("FAIL mid_reach4: got %0d tokens exp 4", tok_cnt - base); end
        rst = 1'b0;
        #1;
        checks++;
        if ({tok_valid, busy, done, err, k_rd_en, tok_type, tok_idx} !== 15'd0) begin
            failures++;
            $display("FAIL mid_reset_outputs: got %h exp 0",
                     {tok_valid, busy, done, err, k_rd_en, tok_type, tok_idx});
        end
        @(negedge clk1);
        rst = 1'b1;
        clear_table();
        smat[1][2] = 8'd1;
        base = tok_cnt;
        pulse_start(8'd2);
        wait_done(100, seen);
        checks++;
        if (!seen || tok_cnt - base != 4) begin
            failures++;
            $display("FAIL mid_n2_count: got seen %0d count %0d exp 1 4", seen, tok_cnt - base);
        end
        for (int t = 0; t < 4; t++) begin
            checks++;
            if (log_type[8'(base + t)] !== et[t] || log_idx[8'(base + t)] !== ei[t]) begin
                failures++;
                $display("FAIL mid_n2_tok%0d: got type %0d idx %0d exp type %0d idx %0d", t,
                         log_type[8'(base + t)], log_idx[8'(base + t)], et[t], ei[t]);
            end
        end
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL mid_n2_err: got %b exp 0", err); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_n3();
        test_back_to_back_backpressure();
        test_illegal_split();
        test_bad_n();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
